csi2_raw10_word_packer: RTL and testbench



---
 rtl/axi4_stream_if.sv | 29 ++
 rtl/csi2_raw10_word_packer.sv | 132 +++++++++++++
 tb/tb_csi2_raw10_word_packer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle used for both sides of the RAW10 word packer.
//   DATA_W : tdata width in bits (a multiple of 8); tkeep/tstrb are DATA_W/8 bits.
//   master : drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser and samples tready.
//   slave  : samples the payload signals and drives tready.
interface axi4_stream_if #(
  parameter int DATA_W = 32
);
  localparam int KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tlast;
  logic [0:0]        tid;
  logic [0:0]        tdest;
  logic [0:0]        tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/csi2_raw10_word_packer.sv
// Gearbox from the 32-bit CSI-2 long-packet payload stream to 40-bit RAW10
// groups (4 pixel MSB bytes + 1 packed LSB byte). Line boundaries (tlast)
// are carried through; a line tail that is not a whole group is discarded
// and flagged on len_err_o.
//
// Ports:
//   clk_i     : core clock
//   srst_i    : synchronous active-high reset
//   pkt_i     : slave stream, 32-bit tdata, 4-bit tkeep, little-endian bytes
//   pkt_o     : master stream, 40-bit tdata, byte k at [8k+7:8k]
//   len_err_o : one-cycle pulse when a malformed line tail is dropped
module csi2_raw10_word_packer (
  input  logic         clk_i,
  input  logic         srst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o,
  output logic         len_err_o
);

  logic [7:0] byte_buf_q [9];
  logic [7:0] byte_buf_d [9];
  logic [3:0] fill_q, fill_d;
  logic       pending_last_q, pending_last_d;
  logic       len_err_q, len_err_d;

  logic [7:0] in_byte [4];
  logic [7:0] shifted [9];
  logic       out_vld, out_fire, in_rdy, in_fire;
  logic [3:0] n_bytes, fill_shift, fill_new, wr_idx;
  logic       unused_in;

  // Only a contiguous run of low bytes is a legal tail; anything else
  // contributes no bytes.
  function automatic logic [3:0] keep_to_count(input logic [3:0] keep);
    case (keep)
      4'b0001: keep_to_count = 4'd1;
      4'b0011: keep_to_count = 4'd2;
      4'b0111: keep_to_count = 4'd3;
      4'b1111: keep_to_count = 4'd4;
      default: keep_to_count = 4'd0;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_byte[k] = pkt_i.tdata[8*k +: 8];
    end

    out_vld  = (fill_q >= 4'd5);
    out_fire = out_vld && pkt_o.tready;
    // Combinational path from pkt_o.tready lets a group leave and a word
    // arrive in the same cycle, sustaining 5 words in : 4 groups out.
    in_rdy   = !pending_last_q && ((fill_q <= 4'd4) || out_fire);
    in_fire  = pkt_i.tvalid && in_rdy;

    n_bytes = 4'd0;
    if (in_fire) begin
      n_bytes = pkt_i.tlast ? keep_to_count(pkt_i.tkeep) : 4'd4;
    end

    // Shift out the emitted group first, then append behind what remains.
    fill_shift = out_fire ? (fill_q - 4'd5) : fill_q;
    for (int i = 0; i < 4; i++) begin
      shifted[i] = out_fire ? byte_buf_q[i+5] : byte_buf_q[i];
    end
    for (int i = 4; i < 9; i++) begin
      shifted[i] = out_fire ? 8'd0 : byte_buf_q[i];
    end

    wr_idx = '0;
    for (int i = 0; i < 9; i++) begin
      byte_buf_d[i] = shifted[i];
    end
    for (int k = 0; k < 4; k++) begin
      wr_idx = fill_shift + 4'(k);
      if (4'(k) < n_bytes) begin
        byte_buf_d[wr_idx] = in_byte[k];
      end
    end
    fill_new = fill_shift + n_bytes;

    fill_d         = fill_new;
    pending_last_d = pending_last_q;
    len_err_d      = 1'b0;
    if (in_fire && pkt_i.tlast) begin
      pending_last_d = 1'b1;
    end else if (pending_last_q && (fill_new < 4'd5)) begin
      // Line finished: any leftover bytes cannot form a group and are dropped.
      pending_last_d = 1'b0;
      if (fill_new != 4'd0) begin
        len_err_d = 1'b1;
        fill_d    = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      fill_q         <= 4'd0;
      pending_last_q <= 1'b0;
      len_err_q      <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        byte_buf_q[i] <= 8'd0;
      end
    end else begin
      fill_q         <= fill_d;
      pending_last_q <= pending_last_d;
      len_err_q      <= len_err_d;
      for (int i = 0; i < 9; i++) begin
        byte_buf_q[i] <= byte_buf_d[i];
      end
    end
  end

  assign pkt_i.tready = in_rdy;

  assign pkt_o.tvalid = out_vld;
  assign pkt_o.tdata  = {byte_buf_q[4], byte_buf_q[3], byte_buf_q[2],
                         byte_buf_q[1], byte_buf_q[0]};
  assign pkt_o.tlast  = pending_last_q && out_vld;
  assign pkt_o.tkeep  = '1;
  assign pkt_o.tstrb  = '1;
  assign pkt_o.tid    = '0;
  assign pkt_o.tdest  = '0;
  assign pkt_o.tuser  = '0;

  assign len_err_o = len_err_q;

  // Sideband inputs carry no meaning for this block.
  assign unused_in = ^{pkt_i.tstrb, pkt_i.tid, pkt_i.tdest, pkt_i.tuser};

endmodule

// File: tb/tb_csi2_raw10_word_packer.sv
module tb_csi2_raw10_word_packer;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic len_err;

  axi4_stream_if #(.DATA_W(32)) in_if ();
  axi4_stream_if #(.DATA_W(40)) out_if ();

  csi2_raw10_word_packer dut (
    .clk_i    (clk),
    .srst_i   (srst),
    .pkt_i    (in_if),
    .pkt_o    (out_if),
    .len_err_o(len_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  logic [40:0] exp_q [$];
  logic        held_v = 1'b0;
  logic [40:0] held;

  logic       bp_en = 1'b0;
  logic       rdy_level = 1'b1;
  int         bp_phase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output ready: fixed level, or the 1,0,0,1 backpressure pattern.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_if.tready = (bp_phase == 0) || (bp_phase == 3);
      bp_phase = (bp_phase + 1) % 4;
    end else begin
      out_if.tready = rdy_level;
      bp_phase = 0;
    end
  end

  // Monitor: scoreboard pop on every output fire, stability and input-stall
  // checks whenever an output is held.
  always @(negedge clk) begin
    if (srst) begin
      held_v = 1'b0;
    end else begin
      if (len_err) err_cnt++;
      if (held_v && out_if.tvalid) begin
        check("held_stable", 64'({out_if.tlast, out_if.tdata}), 64'(held));
      end
      if (out_if.tvalid && out_if.tready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'({out_if.tlast, out_if.tdata}), 64'h1_DEAD_BEEF_00);
        end else begin
          check("out_group", 64'({out_if.tlast, out_if.tdata}), 64'(exp_q.pop_front()));
        end
      end else if (out_if.tvalid) begin
        held_v = 1'b1;
        held   = {out_if.tlast, out_if.tdata};
        check("in_stalled_when_full", 64'(in_if.tready), 64'h0);
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int waits);
    logic r;
    logic ok;
    ok = 1'b0;
    waits = 0;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      r = in_if.tready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) check("send_timeout", 64'h0, 64'h1);
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drained"}, 64'(exp_q.size()), 64'h0);
    check({name, "_tvalid_idle"}, 64'(out_if.tvalid), 64'h0);
    check({name, "_fill_zero"}, 64'(dut.fill_q), 64'h0);
  endtask

  task automatic line20(output int stalls);
    int w;
    logic [7:0] b [4];
    logic [31:0] word;
    stalls = 0;
    exp_q.push_back({1'b0, 40'h04_03_02_01_00});
    exp_q.push_back({1'b0, 40'h09_08_07_06_05});
    exp_q.push_back({1'b0, 40'h0E_0D_0C_0B_0A});
    exp_q.push_back({1'b1, 40'h13_12_11_10_0F});
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'(4*j + k);
      word = {b[3], b[2], b[1], b[0]};
      send(word, 4'hF, (j == 4), w);
      stalls += w;
    end
  endtask

  task automatic minimal_line(input string name);
    int w;
    int e0;
    e0 = err_cnt;
    exp_q.push_back({1'b1, 40'h55_44_33_22_11});
    send(32'h44332211, 4'hF, 1'b0, w);
    send(32'h00000055, 4'h1, 1'b1, w);
    drain(name);
    check({name, "_no_err"}, 64'(err_cnt - e0), 64'h0);
  endtask

  initial begin
    int w;
    int e0;
    int stalls;

    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tstrb  = '1;
    in_if.tlast  = 1'b0;
    in_if.tid    = '0;
    in_if.tdest  = '0;
    in_if.tuser  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(out_if.tvalid), 64'h0);
    check("rst_tlast", 64'(out_if.tlast), 64'h0);
    check("rst_tdata", 64'(out_if.tdata), 64'h0);
    check("rst_len_err", 64'(len_err), 64'h0);
    check("rst_fill", 64'(dut.fill_q), 64'h0);
    @(posedge clk);
    #1 srst = 1'b0;

    // 1: minimal line
    minimal_line("t1");

    // 2: 20-byte line at full rate
    e0 = err_cnt;
    line20(stalls);
    check("t2_input_never_stalled", 64'(stalls), 64'h0);
    drain("t2");
    check("t2_no_err", 64'(err_cnt - e0), 64'h0);

    // 3: same line under 1,0,0,1 backpressure
    e0 = err_cnt;
    bp_en = 1'b1;
    line20(stalls);
    drain("t3");
    bp_en = 1'b0;
    check("t3_no_err", 64'(err_cnt - e0), 64'h0);

    // 4: malformed 7-byte line, then a clean line starts at buf[0]
    e0 = err_cnt;
    exp_q.push_back({1'b1, 40'h04_03_02_01_00});
    send(32'h03020100, 4'hF, 1'b0, w);
    send(32'h00060504, 4'h7, 1'b1, w);
    drain("t4");
    check("t4_one_err_pulse", 64'(err_cnt - e0), 64'h1);
    minimal_line("t4_next");

    // Zero-payload line: no output, no error
    e0 = err_cnt;
    send(32'h00000000, 4'h0, 1'b1, w);
    drain("t_zero");
    check("t_zero_no_err", 64'(err_cnt - e0), 64'h0);

    // 5: back-to-back lines, B must wait for A's last group
    e0 = err_cnt;
    exp_q.push_back({1'b0, 40'hA4_A3_A2_A1_A0});
    exp_q.push_back({1'b1, 40'hA9_A8_A7_A6_A5});
    exp_q.push_back({1'b1, 40'hB4_B3_B2_B1_B0});
    send(32'hA3A2A1A0, 4'hF, 1'b0, w);
    send(32'hA7A6A5A4, 4'hF, 1'b0, w);
    send(32'h0000A9A8, 4'h3, 1'b1, w);
    send(32'hB3B2B1B0, 4'hF, 1'b0, w);
    check("t5_b_held_off", 64'(w > 0), 64'h1);
    send(32'h000000B4, 4'h1, 1'b1, w);
    drain("t5");
    check("t5_no_err", 64'(err_cnt - e0), 64'h0);

    // 6: reset mid-line with output stalled
    e0 = err_cnt;
    rdy_level = 1'b0;
    send(32'h03020100, 4'hF, 1'b0, w);
    send(32'h07060504, 4'hF, 1'b0, w);
    srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    rdy_level = 1'b1;
    @(negedge clk);
    check("t6_tvalid_cleared", 64'(out_if.tvalid), 64'h0);
    check("t6_fill_cleared", 64'(dut.fill_q), 64'h0);
    check("t6_len_err_low", 64'(len_err), 64'h0);
    @(posedge clk);
    #1;
    minimal_line("t6_after_rst");
    check("t6_no_err", 64'(err_cnt - e0), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
